sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Single-clock, parametrised FIFO for same-domain buffering where the dual-clock FIFO's
//  synchroniser latency is wasted. Depth 2**ADDRWIDTH.
//  Adds over the dual-clock FIFO: exact fill count, programmable almost-full/almost-empty
//  thresholds, and overflow/underflow error pulses.
//  Optional first-word-fall-through (FWFT) read mode.
// PARAMETERS
//  DATAWIDTH      8  word width in bits
//  ADDRWIDTH      3  address bits; DEPTH = 2**ADDRWIDTH
//  AFULL_THRESH   6  almost_full asserted when count >= AFULL_THRESH (1..DEPTH)
//  AEMPTY_THRESH  1  almost_empty asserted when count <= AEMPTY_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1              single clock, rising edge
//  rst_n         in   1              asynchronous active-low reset
//  wenable       in   1              write request
//  DataIn        in   DATAWIDTH      write data
//  full          out  1              count == DEPTH
//  almost_full   out  1              count >= AFULL_THRESH
//  overflow      out  1              1-cycle pulse: write attempted while full
//  renable       in   1              read request / pop
//  DataOut       out  DATAWIDTH      read data
//  empty         out  1              count == 0
//  almost_empty  out  1              count <= AEMPTY_THRESH
//  underflow     out  1              1-cycle pulse: read attempted while empty
//  count         out  ADDRWIDTH+1    current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers=0, count=0, empty=1, full=0,
//    almost_empty=1, almost_full=(AFULL_THRESH==0), overflow=0, underflow=0, DataOut=0.
//  - Pointers: ADDRWIDTH+1-bit binary; MSB is the wrap bit. Address = low ADDRWIDTH bits.
//    Pointers wrap naturally from DEPTH*2-1 to 0.
//  - Write accept: wacc = wenable & ~full. Read accept: racc = renable & ~empty.
//    A write while full is dropped even if a read occurs in the same cycle.
//  - Flags use registered state; no comb path from request inputs to flags.
//  - Every edge: count <= count + wacc - racc. Flags are registered from next-count, so
//    count, full, empty, almost_* change together on the edge after the accepting cycle.
//  - Simultaneous wacc & racc: count unchanged; both pointers advance.
//  - Empty + simultaneous wenable/renable: write accepted, read ignored, underflow pulses.
//  - overflow <= wenable & full; underflow <= renable & empty. Registered; high for exactly
//    one cycle per offending cycle. Not sticky.
//  - Read data, default (macro undefined): DataOut <= mem[raddr] on racc, visible the
//    cycle after racc; holds its value otherwise.
//  - Storage: write port synchronous on wacc; read port combinational.
// CONFIGURATION
//  - SYNC_FIFO_FWFT_EN defined: DataOut = mem[raddr] combinationally.
//    * Head word is valid whenever empty==0; racc pops it.
//    * Word written at edge N is on DataOut from N+1, alongside empty=0.
//    * DataOut is don't-care while empty.
//  - Undefined: 1-cycle registered read as above.
//  - Flags, count, overflow and underflow are identical in both modes.
// STRUCTURE
//  - Shared package fifo_pkg holds:
//    * clog2-style width helper
//    * localparam DEPTH
//    * threshold legality checks (elaboration-time error if AFULL_THRESH > DEPTH or
//      AEMPTY_THRESH >= DEPTH)
//  - Storage reuses the existing dual_port_ram sub-module (single clk on wclk).
//  - Pointer/count/flag logic and the read register live in this module; no other
//    sub-modules.
// TESTING  (DATAWIDTH=8, ADDRWIDTH=3, AFULL_THRESH=6, AEMPTY_THRESH=1)
//  1. Reset mid-traffic: assert rst_n=0 asynchronously after 5 writes
//     -> count=0, empty=1, almost_empty=1, DataOut=0 before the next clk edge.
//  2. Fill: write 0x10..0x17 -> count steps 1..8; almost_empty drops at count=2;
//     almost_full rises at count=6; full=1 at count=8.
//     A 9th write -> overflow pulses once, count stays 8.
//  3. Drain from full: read 8 times -> data 0x10..0x17 in order (non-FWFT: 1 cycle after
//     each renable); empty=1 after the 8th. A 9th read -> underflow pulse, DataOut holds 0x17.
//  4. Wrap: 20 interleaved write/read pairs of 0x00..0x13 at count=3
//     -> pointers wrap twice, count stays 3, output order preserved.
//  5. Boundaries: at full, assert renable+wenable together -> read accepted, write dropped,
//     overflow=1, count=7. At empty, same -> write accepted, underflow=1, count=1.
//  6. SYNC_FIFO_FWFT_EN build: write 0xA5 into empty FIFO -> next cycle empty=0 and
//     DataOut=0xA5 with no renable; renable pops it, empty=1 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and threshold legality check for the FIFO
// Purpose: width/depth helpers used by sync_fifo_flags to size pointers and count,
//          plus the elaboration-time legality test for the almost-full/empty levels.
package fifo_pkg;

  localparam int DEF_ADDRWIDTH = 3;

  // Ceiling log2; value 1 yields 0.
  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int fifo_depth(input int addrwidth);
    return 1 << addrwidth;
  endfunction

  localparam int DEPTH = fifo_depth(DEF_ADDRWIDTH);

  // almost_full level may reach DEPTH; almost_empty level must stay below it.
  function automatic bit thresh_legal(input int afull, input int aempty, input int depth);
    return (afull >= 0) && (afull <= depth) && (aempty >= 0) && (aempty < depth);
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - simple dual-port RAM, synchronous write, combinational read
// Purpose: FIFO storage array.
// Ports:
//   i_wclk   write clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from i_raddr)
module dual_port_ram #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 3
) (
  input  logic                 i_wclk,
  input  logic                 i_we,
  input  logic [ADDRWIDTH-1:0] i_waddr,
  input  logic [DATAWIDTH-1:0] i_wdata,
  input  logic [ADDRWIDTH-1:0] i_raddr,
  output logic [DATAWIDTH-1:0] o_rdata
);

  logic [DATAWIDTH-1:0] r_mem [0:(1<<ADDRWIDTH)-1];

  always_ff @(posedge i_wclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with fill count, almost flags and error pulses
// Purpose: same-domain FIFO, depth 2**ADDRWIDTH, registered flags.
// Optional macro SYNC_FIFO_FWFT_EN: first-word-fall-through read (DataOut shows head word).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   wenable       write request;  DataIn write data
//   full          count == DEPTH; almost_full count >= AFULL_THRESH
//   overflow      one-cycle pulse, write attempted while full
//   renable       read request / pop; DataOut read data
//   empty         count == 0;     almost_empty count <= AEMPTY_THRESH
//   underflow     one-cycle pulse, read attempted while empty
//   count         occupancy 0..DEPTH
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH     = 8,
  parameter int ADDRWIDTH     = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wenable,
  input  logic [DATAWIDTH-1:0] DataIn,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  input  logic                 renable,
  output logic [DATAWIDTH-1:0] DataOut,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 underflow,
  output logic [ADDRWIDTH:0]   count
);

  localparam int FIFO_DEPTH = fifo_depth(ADDRWIDTH);
  // Count must hold 0..DEPTH inclusive, which is also the wrap-bit pointer width.
  localparam int PTR_W      = fifo_clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] AF_LVL   = PTR_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] AE_LVL   = PTR_W'(AEMPTY_THRESH);
  localparam logic             AF_RST   = (AFULL_THRESH == 0);

  if (!thresh_legal(AFULL_THRESH, AEMPTY_THRESH, FIFO_DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_flags: AFULL_THRESH must be <= DEPTH and AEMPTY_THRESH < DEPTH");
  end

  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [PTR_W-1:0]     r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_afull;
  logic                 r_aempty;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_wacc;
  logic                 w_racc;
  logic [PTR_W-1:0]     w_count_nxt;
  logic [DATAWIDTH-1:0] w_rdata;

  // Accepts use only registered flags, so a write at full is dropped even when a
  // read pops in the same cycle.
  assign w_wacc      = wenable & ~r_full;
  assign w_racc      = renable & ~r_empty;
  assign w_count_nxt = r_count + {{(PTR_W-1){1'b0}}, w_wacc} - {{(PTR_W-1){1'b0}}, w_racc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= AF_RST;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wacc) r_wptr <= r_wptr + PTR_W'(1);
      if (w_racc) r_rptr <= r_rptr + PTR_W'(1);
      // Flags derive from the next count so they move together with count.
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CNT_FULL);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= AF_LVL);
      r_aempty <= (w_count_nxt <= AE_LVL);
      r_ovf    <= wenable & r_full;
      r_unf    <= renable & r_empty;
    end
  end

  dual_port_ram #(
    .DATAWIDTH (DATAWIDTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_ram (
    .i_wclk  (clk),
    .i_we    (w_wacc),
    .i_waddr (r_wptr[ADDRWIDTH-1:0]),
    .i_wdata (DataIn),
    .i_raddr (r_rptr[ADDRWIDTH-1:0]),
    .o_rdata (w_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; it is meaningful only while empty is low.
  assign DataOut = w_rdata;
`else
  logic [DATAWIDTH-1:0] r_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_dout <= '0;
    else if (w_racc) r_dout <= w_rdata;
  end

  assign DataOut = r_dout;
`endif

  assign full         = r_full;
  assign almost_full  = r_afull;
  assign overflow     = r_ovf;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign underflow    = r_unf;
  assign count        = r_count;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard testbench for sync_fifo_flags
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wenable = 1'b0;
  logic          renable = 1'b0;
  logic [DW-1:0] DataIn = '0;
  logic [DW-1:0] DataOut;
  logic          full, almost_full, overflow, empty, almost_empty, underflow;
  logic [AW:0]   count;

  sync_fifo_flags #(
    .DATAWIDTH     (DW),
    .ADDRWIDTH     (AW),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wenable      (wenable),
    .DataIn       (DataIn),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .renable      (renable),
    .DataOut      (DataOut),
    .empty        (empty),
    .almost_empty (almost_empty),
    .underflow    (underflow),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit full, empty, af, ae, ov, un;
    bit dchk;
    int dout;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];
  int   m_dout;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: occupancy is the length of a plain queue.
  task automatic step(input bit wen, input bit ren, input int din);
    exp_t e;
    bit full_pre, empty_pre;
    full_pre  = (mq.size() == DEPTH);
    empty_pre = (mq.size() == 0);
    if (ren && !empty_pre) m_dout = mq.pop_front();
    if (wen && !full_pre)  mq.push_back(din & 8'hFF);
    e.count = mq.size();
    e.full  = (e.count == DEPTH);
    e.empty = (e.count == 0);
    e.af    = (e.count >= AF);
    e.ae    = (e.count <= AE);
    e.ov    = wen && full_pre;
    e.un    = ren && empty_pre;
`ifdef SYNC_FIFO_FWFT_EN
    e.dchk  = (e.count > 0);
    e.dout  = e.dchk ? mq[0] : 0;
`else
    e.dchk  = 1'b1;
    e.dout  = m_dout;
`endif
    exp_q.push_back(e);
    wenable = wen;
    renable = ren;
    DataIn  = DW'(din);
    @(negedge clk);
  endtask

  // Monitor: one expected record per accepted clock edge.
  always @(posedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      chk("count", int'(count), e.count);
      chk("full", int'(full), int'(e.full));
      chk("empty", int'(empty), int'(e.empty));
      chk("almost_full", int'(almost_full), int'(e.af));
      chk("almost_empty", int'(almost_empty), int'(e.ae));
      chk("overflow", int'(overflow), int'(e.ov));
      chk("underflow", int'(underflow), int'(e.un));
      if (e.dchk) chk("DataOut", int'(DataOut), e.dout);
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_aempty"}, int'(almost_empty), 1);
    chk({tag, "_afull"}, int'(almost_full), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_unf"}, int'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, "_dout"}, int'(DataOut), 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_dout = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("init");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset after five writes, checked before the next edge
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h30 + i);
    wenable = 1'b0;
    renable = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    mq.delete();
    m_dout = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: fill, then one write too many
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h10 + i);
    step(1'b1, 1'b0, 8'hEE);
    // 3: drain in order, then one read too many
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);

    // 4: pointer wrap at steady occupancy 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hA0 + i);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, i);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0);

    // 5: simultaneous requests at full and at empty
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h50 + i);
    step(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b0, 0);

    // 6: write into empty then pop (exercises fall-through when enabled)
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);

    // Random traffic in phases biased toward filling, draining and balance
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      int rp;
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int i = 0; i < 80; i++)
        step($urandom_range(99) < wp, $urandom_range(99) < rp, $urandom_range(255));
    end

    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
